// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the decryption-side key schedule:
// FSM state encoding, round constants and the forward S-box.
package aes_pkg;

   localparam int          KEY_W = 128;
   localparam logic [3:0]  NR    = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_SUB  = 2'd2,
      ST_UPD  = 2'd3
   } state_t;

   // Forward S-box, byte 0x00 in the most significant position.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Single-byte S-box lookup.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
   endfunction

   // Round constant for a round number; index 0 and >10 are unused.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_rev_key_schedule_if.sv
// Handshake bundle between the reverse key schedule and its consumer.
interface aes_rev_key_schedule_if;
   import aes_pkg::*;

   logic              start;
   logic [KEY_W-1:0]  last_key;
   logic [KEY_W-1:0]  round_key;
   logic [3:0]        round_idx;
   logic              key_valid;
   logic              key_ready;
   logic              busy;
   logic              done;

   // Consumer / controller side.
   modport master (
      output start, last_key, key_ready,
      input  round_key, round_idx, key_valid, busy, done
   );

   // Key schedule side.
   modport slave (
      input  start, last_key, key_ready,
      output round_key, round_idx, key_valid, busy, done
   );
endinterface

// File: rtl/aes_rev_key_schedule_g_function.sv
// AES key-expansion g-function: RotWord, SubWord with registered S-box
// bytes (1-cycle latency), then round-constant injection in the top byte.
module g_function
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_3,
   input  logic [7:0]  round_number,
   output logic [31:0] word_3_substituted
);

   logic [31:0] r_sub;
   logic [31:0] w_sub;

   // Look up all four input bytes in parallel.
   always_comb begin
      w_sub = {sbox(word_3[31:24]), sbox(word_3[23:16]),
               sbox(word_3[15:8]),  sbox(word_3[7:0])};
   end

   // Register the substituted bytes; cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sub <= 32'h0000_0000;
      end else begin
         r_sub <= w_sub;
      end
   end

   // Rotate left by one byte and apply rcon to the leading byte.
   assign word_3_substituted = {r_sub[23:16] ^ round_number, r_sub[15:8],
                                r_sub[7:0], r_sub[31:24]};

endmodule

// File: rtl/aes_rev_key_schedule.sv
// Decryption-side AES-128 round-key generator. Starting from the round-10
// key it walks the schedule backwards and emits keys 10..0 over a
// valid/ready handshake, so the inverse cipher needs no full key store.
module aes_rev_key_schedule
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   aes_rev_key_schedule_if.slave  io_bus
);

   state_t            r_state;
   logic [KEY_W-1:0]  r_round_key;
   logic [3:0]        r_round_idx;
   logic              r_key_valid;
   logic              r_busy;
   logic              r_done;

   logic [31:0]       w_k0, w_k1, w_k2, w_k3;
   logic [31:0]       w_p0, w_p1, w_p2, w_p3;
   logic [31:0]       w_g;
   logic [7:0]        w_rcon;
   logic [KEY_W-1:0]  w_prev_key;

   // Inverse key step: the three upper words need only XORs of the current
   // key; p0 additionally needs g(p3), which arrives one cycle after SUB.
   always_comb begin
      w_k0       = r_round_key[127:96];
      w_k1       = r_round_key[95:64];
      w_k2       = r_round_key[63:32];
      w_k3       = r_round_key[31:0];
      w_p3       = w_k3 ^ w_k2;
      w_p2       = w_k2 ^ w_k1;
      w_p1       = w_k1 ^ w_k0;
      w_p0       = w_k0 ^ w_g;
      w_rcon     = rcon(r_round_idx);
      w_prev_key = {w_p0, w_p1, w_p2, w_p3};
   end

   // Shared g-function; its input is stable through SUB and UPD because it
   // depends only on the round_key/round_idx registers.
   g_function u_g_function (
      .clk                (clk),
      .rst                (rst),
      .word_3             (w_p3),
      .round_number       (w_rcon),
      .word_3_substituted (w_g)
   );

   // Sequence control: IDLE -> EMIT -> (SUB -> UPD -> EMIT)* -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_round_key <= {KEY_W{1'b0}};
         r_round_idx <= 4'd0;
         r_key_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A start coinciding with the done pulse is dropped.
               if (io_bus.start && !r_done) begin
                  r_round_key <= io_bus.last_key;
                  r_round_idx <= NR;
                  r_key_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= ST_EMIT;
               end else begin
                  r_state     <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (io_bus.key_ready) begin
                  r_key_valid <= 1'b0;
                  if (r_round_idx == 4'd0) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_SUB;
                  end
               end else begin
                  r_state <= ST_EMIT;
               end
            end
            ST_SUB: begin
               r_state <= ST_UPD;
            end
            ST_UPD: begin
               r_round_key <= w_prev_key;
               if (r_round_idx != 4'd0) begin
                  r_round_idx <= r_round_idx - 4'd1;
               end else begin
                  r_round_idx <= r_round_idx;
               end
               r_key_valid <= 1'b1;
               r_state     <= ST_EMIT;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_key_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.round_key = r_round_key;
   assign io_bus.round_idx = r_round_idx;
   assign io_bus.key_valid = r_key_valid;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;

endmodule

// File: tb/tb_aes_rev_key_schedule.sv
// Self-checking bench for aes_rev_key_schedule: a scoreboard queue of
// expected (key, index) pairs, filled from an independent forward/backward
// key-expansion model with a GF(2^8)-derived S-box.
module tb_aes_rev_key_schedule;

   logic clk;
   logic rst;

   aes_rev_key_schedule_if u_if ();

   aes_rev_key_schedule dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
   } exp_t;

   exp_t          sb_q[$];
   int            total = 0;
   int            bad   = 0;
   logic [7:0]    sb_tab[0:255];
   logic [7:0]    rc_tab[0:10];
   logic [127:0]  exp_keys[0:10];
   logic [127:0]  fw_keys[0:10];

   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box from multiplicative inverse plus affine transform.
   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] r;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                     ^ rotl8(inv, 4) ^ 8'h63;
      end
      r = 8'h01;
      rc_tab[0] = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         rc_tab[i] = r;
         r = gmul(r, 8'h02);
      end
   endtask

   function automatic logic [31:0] sub_rot(input logic [31:0] x, input logic [7:0] rc);
      logic [31:0] rot = {x[23:0], x[31:24]};
      return {sb_tab[rot[31:24]] ^ rc, sb_tab[rot[23:16]], sb_tab[rot[15:8]], sb_tab[rot[7:0]]};
   endfunction

   // Forward AES-128 key expansion into fw_keys.
   task automatic fwd_expand(input logic [127:0] k0);
      logic [31:0] w[0:43];
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         if (i % 4 == 0) w[i] = w[i-4] ^ sub_rot(w[i-1], rc_tab[i/4]);
         else            w[i] = w[i-4] ^ w[i-1];
      end
      for (int r = 0; r <= 10; r++)
         fw_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Backward walk from the round-10 key into exp_keys.
   task automatic bwd_expand(input logic [127:0] k10);
      logic [31:0] k0, k1, k2, k3, p0, p1, p2, p3;
      exp_keys[10] = k10;
      for (int r = 10; r >= 1; r--) begin
         {k0, k1, k2, k3} = exp_keys[r];
         p3 = k3 ^ k2;
         p2 = k2 ^ k1;
         p1 = k1 ^ k0;
         p0 = k0 ^ sub_rot(p3, rc_tab[r]);
         exp_keys[r-1] = {p0, p1, p2, p3};
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   // One full sequence. rmode: 0 = ready always high, 1 = random ready.
   // inject: pulse a foreign start at round 5. abort: reset during UPD of round 6.
   task automatic run_vec(input logic [127:0] lk, input bit rmode, input bit inject, input bit abort);
      int           cyc;
      int           h = -1;
      bit           got_done = 1'b0;
      bit           injected = 1'b0;
      bit           prev_stall = 1'b0;
      logic [127:0] prev_key = '0;
      logic [3:0]   prev_idx = '0;
      exp_t         e;
      sb_q.delete();
      for (int r = 10; r >= 0; r--) sb_q.push_back('{key: exp_keys[r], idx: 4'(r)});
      u_if.start    = 1'b1;
      u_if.last_key = lk;
      u_if.key_ready = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
      cyc = 1;
      for (int n = 0; n < 400; n++) begin
         if (u_if.done) begin
            got_done = 1'b1;
            break;
         end
         if (cyc == 1) chk("first_valid", 128'(u_if.key_valid), 128'd1);
         if (!rmode) begin
            chk("busy_hi", 128'(u_if.busy), 128'd1);
            chk("valid_pat", 128'(u_if.key_valid), 128'(cyc % 3 == 1));
         end
         if (prev_stall) begin
            chk("hold_key", u_if.round_key, prev_key);
            chk("hold_idx", 128'(u_if.round_idx), 128'(prev_idx));
         end
         if (inject && !injected && u_if.key_valid && u_if.round_idx == 4'd5) begin
            u_if.start    = 1'b1;
            u_if.last_key = ~lk;
            injected      = 1'b1;
         end else begin
            u_if.start = 1'b0;
         end
         if (abort && h >= 0 && cyc == h + 2) begin
            chk("upd_valid_lo", 128'(u_if.key_valid), 128'd0);
            rst = 1'b1;
            #1;
            chk("rst_key", u_if.round_key, 128'd0);
            chk("rst_idx", 128'(u_if.round_idx), 128'd0);
            chk("rst_valid", 128'(u_if.key_valid), 128'd0);
            chk("rst_busy", 128'(u_if.busy), 128'd0);
            chk("rst_done", 128'(u_if.done), 128'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            sb_q.delete();
            return;
         end
         u_if.key_ready = rmode ? ($urandom_range(0, 99) < 45) : 1'b1;
         prev_stall = u_if.key_valid && !u_if.key_ready;
         prev_key   = u_if.round_key;
         prev_idx   = u_if.round_idx;
         if (u_if.key_valid && u_if.key_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 128'd1, 128'd0);
            end else begin
               e = sb_q.pop_front();
               chk("key", u_if.round_key, e.key);
               chk("idx", 128'(u_if.round_idx), 128'(e.idx));
               if (u_if.round_idx == 4'd7) h = cyc;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!got_done) begin
         chk("timeout", 128'd0, 128'd1);
      end else begin
         if (!rmode) chk("done_cyc", 128'(cyc), 128'd32);
         chk("sb_empty", 128'(sb_q.size()), 128'd0);
         chk("idle_busy", 128'(u_if.busy), 128'd0);
         chk("idle_valid", 128'(u_if.key_valid), 128'd0);
      end
   endtask

   initial begin
      rst            = 1'b1;
      u_if.start     = 1'b0;
      u_if.last_key  = '0;
      u_if.key_ready = 1'b0;
      build_tables();
      @(posedge clk); #1;
      chk("reset_key", u_if.round_key, 128'd0);
      chk("reset_idx", 128'(u_if.round_idx), 128'd0);
      chk("reset_valid", 128'(u_if.key_valid), 128'd0);
      chk("reset_busy", 128'(u_if.busy), 128'd0);
      chk("reset_done", 128'(u_if.done), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycle();

      // Reference vector from the forward expansion of the cipher key.
      fwd_expand(FIPS_K0);
      chk("model_k10", fw_keys[10], FIPS_K10);
      chk("model_k9", fw_keys[9], FIPS_K9);
      for (int r = 0; r <= 10; r++) exp_keys[r] = fw_keys[r];

      run_vec(FIPS_K10, 1'b0, 1'b0, 1'b0);

      // Start in the done cycle is ignored; the next cycle's start is taken.
      u_if.start    = 1'b1;
      u_if.last_key = FIPS_K10;
      @(posedge clk); #1;
      chk("b2b_ignored_busy", 128'(u_if.busy), 128'd0);
      chk("b2b_ignored_valid", 128'(u_if.key_valid), 128'd0);
      chk("done_one_cycle", 128'(u_if.done), 128'd0);
      run_vec(FIPS_K10, 1'b0, 1'b0, 1'b0);
      idle_cycle();

      run_vec(FIPS_K10, 1'b1, 1'b0, 1'b0);
      idle_cycle();

      run_vec(FIPS_K10, 1'b0, 1'b1, 1'b0);
      idle_cycle();

      run_vec(FIPS_K10, 1'b0, 1'b0, 1'b1);
      run_vec(FIPS_K10, 1'b0, 1'b0, 1'b0);
      idle_cycle();

      // All-zero final key against the backward model, cross-checked forward.
      bwd_expand(128'd0);
      fwd_expand(exp_keys[0]);
      chk("zero_roundtrip", fw_keys[10], 128'd0);
      run_vec(128'd0, 1'b0, 1'b0, 1'b0);
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_rev_key_schedule.md
# aes_rev_key_schedule

- Decryption-side AES-128 round-key generator.
- Loads the final (round-10) round key and walks the key schedule backwards, producing round keys 10, 9, …, 0 in that order, each through a valid/ready handshake.
- Feeds the inverse-cipher pipeline, so decryption needs no 176-byte key store.
- Each backward step reuses the encryption-side g-function, which has a registered S-box with 1-cycle latency.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a sequence; sampled only in IDLE.
- last_key  in  128  round-10 key, [127:96]=w0 … [31:0]=w3; sampled on the start edge.
- round_key  out  128  current round key, same word order.
- round_idx  out  4  round number of round_key (10 down to 0).
- key_valid  out  1  round_key/round_idx valid.
- key_ready  in  1  consumer accepts the key when key_valid & key_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, EMIT, SUB, UPD.
- IDLE:
  - On start: round_key <= last_key, round_idx <= 10, go to EMIT.
  - start in any other state is ignored.
- EMIT:
  - key_valid=1; round_key and round_idx are held stable while key_ready=0.
  - On handshake with round_idx==0: go to IDLE and pulse done.
  - On handshake otherwise: go to SUB.
- Backward step. With current key words k0..k3, the previous key words are:
  - p3 = k3^k2
  - p2 = k2^k1
  - p1 = k1^k0
  - p0 = k0 ^ g(p3, rcon[round_idx])
- g(x, rc), as in encryption:
  - with S-box bytes s0=S(x[31:24]), s1=S(x[23:16]), s2=S(x[15:8]), s3=S(x[7:0]), the result is {s1^rc, s2, s3, s0}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (8 bits). rcon[0] is unused.
- SUB:
  - p3 drives the g-function input; the S-box registers it at the end of the cycle.
  - Go to UPD.
- UPD:
  - g output is now valid.
  - round_key <= {p0,p1,p2,p3}, round_idx <= round_idx-1, go to EMIT.
- p3 and the rcon index are taken from the round_key/round_idx registers, which do not change during SUB/UPD, so the g input is stable across both cycles.
- round_idx never wraps; the UPD transition is unreachable with round_idx==0.

## Timing
- Reset values: round_key=0, round_idx=0, key_valid=0, busy=0, done=0, state=IDLE. The S-box registers also clear.
- rst mid-sequence aborts immediately to IDLE. No done pulse is issued, and the next start begins a fresh sequence.
- Start edge at cycle 0: key 10 is valid in cycle 1.
- Handshake in cycle t: the next key is valid in cycle t+3 (SUB at t+1, UPD at t+2, EMIT at t+3).
- With key_ready tied high: keys are valid in cycles 1, 4, …, 31, and done pulses in cycle 32. busy is high in cycles 1-31.
- key_valid is low in SUB and UPD.
- done is high for exactly one cycle, the first cycle back in IDLE.
- start asserted in the same cycle as done is ignored. A start is accepted from the cycle after done (state IDLE).

## Structure
- The shared package aes_pkg holds:
  - the state enum;
  - the rcon table as a constant function of a 4-bit index;
  - the AES-128 constants NR=10 and the key width of 128.
- One sub-module: the existing g_function (clk, rst, word_3, round_number, word_3_substituted).
  - Instantiate it with word_3=p3 and round_number=rcon[round_idx].
  - No new S-box instance.

## Test plan
- FIPS-197 A.1 vector, key_ready=1:
  - last_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 9 key = ac7766f319fadc2128d12941575c006e.
  - Round 0 key = 2b7e151628aed2a6abf7158809cf4f3c.
  - All 11 keys match the forward expansion.
  - done pulses in cycle 32.
- Backpressure:
  - Random key_ready on the same vector.
  - Key and index stay stable while key_valid & !key_ready.
  - The same 11 keys appear with no duplicates or skips.
- start while busy:
  - Pulse start with a different last_key at round 5.
  - The sequence is unaffected and the original round-0 key is still produced.
- Reset mid-run:
  - Assert rst during UPD of round 6.
  - All outputs go to their reset values at once.
  - A new start reproduces the full vector from round 10.
- Back-to-back:
  - start in the done cycle is ignored.
  - start on the next cycle produces key 10 one cycle later.
- All-zero last_key:
  - The backward sequence matches a software model.
  - This exercises S(00)=63 and the rcon byte placement in the top byte.
